dmem_ctrl: RTL

//  Data-memory controller that sits directly downstream of the cpu data-memory port.
//  It serves single-word load/store requests from a word-addressed on-chip RAM.
//  A programmable wait-state count models slow memory and exercises the memory-stage stall path.
//  mem_valid drives the cpu mem_valid input; the cpu stalls its memory stage until mem_valid pulses.

---
 rtl/dmem_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - word-addressed data-memory controller with programmable wait states
module dmem_ctrl #(
    parameter int    DEPTH     = 1024,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic [31:0] mem_addr,
    input  logic        mem_write,
    input  logic [31:0] mem_write_data,
    output logic        mem_valid,
    output logic [31:0] mem_read_data,
    output logic        mem_err,
    output logic        busy
);
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] LIMIT = 32'(DEPTH) << 2;
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic          accept;
    logic [31:0]   addr_q, wdata_q;
    logic          write_q;
    logic [31:0]   ram [DEPTH];

    logic [31:0]   cur_addr, cur_wdata;
    logic          cur_write, cur_in_range, commit;
    logic [AW-1:0] cur_idx;

    // With zero wait states RESP is entered on the accept edge itself, so the
    // commit must see the live request rather than the not-yet-latched copy.
    assign cur_addr     = (state == IDLE) ? mem_addr       : addr_q;
    assign cur_wdata    = (state == IDLE) ? mem_write_data : wdata_q;
    assign cur_write    = (state == IDLE) ? mem_write      : write_q;
    assign cur_in_range = cur_addr < LIMIT;
    assign cur_idx      = cur_addr[AW+1:2];
    assign commit       = (state_nxt == RESP);
    assign busy         = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    accept    = 1'b1;
                    cnt_nxt   = LAT;
                    state_nxt = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            write_q       <= 1'b0;
            mem_valid     <= 1'b0;
            mem_err       <= 1'b0;
            mem_read_data <= 32'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mem_valid <= commit;
            mem_err   <= commit & ~cur_in_range;
            if (accept) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_write_data;
                write_q <= mem_write;
            end
            if (commit && !cur_write)
                mem_read_data <= cur_in_range ? ram[cur_idx] : 32'd0;
        end
    end

    // RAM has no reset; the rst gate keeps a store from landing while reset is held.
    always_ff @(posedge clk) begin
        if (!rst && commit && cur_write && cur_in_range)
            ram[cur_idx] <= cur_wdata;
    end

endmodule
